// File: rtl/axis_frame_len_rx.sv
// AXI-stream frame receiver: registers beats through to the output port and
// reports one {length, bad} status word per completed frame.
module axis_frame_len_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned MAX_LEN    = 1518
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  status_valid,
    input  logic                  status_ready,
    output logic [LEN_WIDTH-1:0]  status_len,
    output logic                  status_bad
);

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_cnt_q, len_cnt_d;
    logic                  bad_acc_q, bad_acc_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  st_valid_q, st_valid_d;
    logic [LEN_WIDTH-1:0]  st_len_q, st_len_d;
    logic                  st_bad_q, st_bad_d;

    logic                  in_ready;
    logic                  acc;
    logic [LEN_WIDTH-1:0]  nxt_len;
    logic                  beat_bad;

    // Handshake, counting and status capture.
    always_comb begin
        state_d    = state_q;
        len_cnt_d  = len_cnt_q;
        bad_acc_d  = bad_acc_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        st_valid_d = st_valid_q;
        st_len_d   = st_len_q;
        st_bad_d   = st_bad_q;

        // A pending unconsumed status word blocks input so it can never be overwritten.
        in_ready = (output_axis_tready | ~tvalid_q) & ~(st_valid_q & ~status_ready);
        acc      = input_axis_tvalid & in_ready;
        nxt_len  = (len_cnt_q == '1) ? len_cnt_q : len_cnt_q + LEN_WIDTH'(1);
        beat_bad = bad_acc_q | input_axis_tuser | (32'(nxt_len) > MAX_LEN);

        if (acc) begin
            tdata_d  = input_axis_tdata;
            tvalid_d = 1'b1;
            tlast_d  = input_axis_tlast;
            tuser_d  = input_axis_tuser;
        end else if (output_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (st_valid_q & status_ready) begin
            st_valid_d = 1'b0;
        end

        if (acc) begin
            if (input_axis_tlast) begin
                st_len_d   = nxt_len;
                st_bad_d   = beat_bad;
                st_valid_d = 1'b1;
                len_cnt_d  = '0;
                bad_acc_d  = 1'b0;
                state_d    = IDLE;
            end else begin
                len_cnt_d  = nxt_len;
                bad_acc_d  = beat_bad;
                state_d    = IN_FRAME;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            len_cnt_q  <= '0;
            bad_acc_q  <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            st_valid_q <= 1'b0;
            st_len_q   <= '0;
            st_bad_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_cnt_q  <= len_cnt_d;
            bad_acc_q  <= bad_acc_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            st_valid_q <= st_valid_d;
            st_len_q   <= st_len_d;
            st_bad_q   <= st_bad_d;
        end
    end

    assign input_axis_tready  = in_ready;
    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign output_axis_tlast  = tlast_q;
    assign output_axis_tuser  = tuser_q;
    assign status_valid       = st_valid_q;
    assign status_len         = st_len_q;
    assign status_bad         = st_bad_q;

endmodule
